// File: rtl/data_stack.sv
// Data stack for a stack CPU: registered top-of-stack T plus DEPTH cells below it.
// dsp counts valid cells; N is read combinationally from the cell just under T.
module data_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       write_enable,
    input  logic [1:0]                 delta,
    input  logic [WIDTH-1:0]           data_stack_next_value,
    input  logic                       error_clear,
    output logic [WIDTH-1:0]           data_stack_current_top,
    output logic [WIDTH-1:0]           data_stack_current_next_top,
    output logic [$clog2(DEPTH):0]     dsp,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_COUNT = PW'(DEPTH);

    logic [WIDTH-1:0] cells [DEPTH];
    logic [WIDTH-1:0] top;
    logic [PW-1:0]    dsp_q;
    logic [PW-1:0]    dsp_next;
    logic             full;
    logic             do_push;
    logic             set_overflow;
    logic             set_underflow;
    logic [AW-1:0]    next_idx;

    assign full = (dsp_q == FULL_COUNT);

    always_comb begin
        dsp_next      = dsp_q;
        do_push       = 1'b0;
        set_overflow  = 1'b0;
        set_underflow = 1'b0;
        if (write_enable) begin
            case (delta)
                2'b01: begin
                    if (full) set_overflow = 1'b1;
                    else begin
                        do_push  = 1'b1;
                        dsp_next = dsp_q + PW'(1);
                    end
                end
                2'b11: begin
                    if (dsp_q >= PW'(1)) dsp_next = dsp_q - PW'(1);
                    else set_underflow = 1'b1;
                end
                2'b10: begin
                    if (dsp_q >= PW'(2)) dsp_next = dsp_q - PW'(2);
                    else begin
                        dsp_next      = '0;
                        set_underflow = 1'b1;
                    end
                end
                default: dsp_next = dsp_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top       <= '0;
            dsp_q     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_enable) begin
                top   <= data_stack_next_value;
                dsp_q <= dsp_next;
            end
            // A new error in the same cycle as error_clear leaves the flag set.
            if (set_overflow) overflow <= 1'b1;
            else if (error_clear) overflow <= 1'b0;
            if (set_underflow) underflow <= 1'b1;
            else if (error_clear) underflow <= 1'b0;
        end
    end

    // Cells are never cleared; stale entries stay hidden because N is gated by dsp.
    always_ff @(posedge clk) begin
        if (!reset && do_push) cells[dsp_q[AW-1:0]] <= top;
    end

    // Low bits minus one wrap DEPTH to DEPTH-1, so the full case needs no extra bit.
    assign next_idx = dsp_q[AW-1:0] - AW'(1);

    assign data_stack_current_top      = top;
    assign data_stack_current_next_top = (dsp_q != '0) ? cells[next_idx] : '0;
    assign dsp                         = dsp_q;

endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack: a reference model fills an expected queue
// as each cycle is driven; entries are popped and compared after the clock edge.
module tb_data_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int PW    = $clog2(DEPTH) + 1;
    localparam int EW    = 2 * WIDTH + PW + 2;

    logic             clk;
    logic             reset;
    logic             write_enable;
    logic [1:0]       delta;
    logic [WIDTH-1:0] data_stack_next_value;
    logic             error_clear;
    logic [WIDTH-1:0] data_stack_current_top;
    logic [WIDTH-1:0] data_stack_current_next_top;
    logic [PW-1:0]    dsp;
    logic             overflow;
    logic             underflow;

    data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk                         (clk),
        .reset                       (reset),
        .write_enable                (write_enable),
        .delta                       (delta),
        .data_stack_next_value       (data_stack_next_value),
        .error_clear                 (error_clear),
        .data_stack_current_top      (data_stack_current_top),
        .data_stack_current_next_top (data_stack_current_next_top),
        .dsp                         (dsp),
        .overflow                    (overflow),
        .underflow                   (underflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [WIDTH-1:0] m_top;
    logic [WIDTH-1:0] m_cells [DEPTH];
    int               m_sp;
    logic             m_ov;
    logic             m_un;

    logic [EW-1:0] exp_q[$];
    int tests;
    int failed;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_cycle(input logic rst, input logic we, input logic [1:0] d,
                               input logic [WIDTH-1:0] v, input logic ec);
        logic [WIDTH-1:0] n;
        if (rst) begin
            m_top = '0;
            m_sp  = 0;
            m_ov  = 1'b0;
            m_un  = 1'b0;
        end else begin
            if (ec) begin
                m_ov = 1'b0;
                m_un = 1'b0;
            end
            if (we) begin
                if (d == 2'b01) begin
                    if (m_sp < DEPTH) begin
                        m_cells[m_sp] = m_top;
                        m_sp++;
                    end else m_ov = 1'b1;
                end else if (d == 2'b11) begin
                    if (m_sp >= 1) m_sp--;
                    else m_un = 1'b1;
                end else if (d == 2'b10) begin
                    if (m_sp >= 2) m_sp -= 2;
                    else begin
                        m_sp = 0;
                        m_un = 1'b1;
                    end
                end
                m_top = v;
            end
        end
        n = (m_sp > 0) ? m_cells[m_sp-1] : '0;
        exp_q.push_back({m_top, n, PW'(m_sp), m_ov, m_un});
    endtask

    // driver: apply one cycle, then compare DUT against the oldest expectation
    task automatic step(input logic rst, input logic we, input logic [1:0] d,
                        input logic [WIDTH-1:0] v, input logic ec);
        logic [EW-1:0] e;
        reset                 = rst;
        write_enable          = we;
        delta                 = d;
        data_stack_next_value = v;
        error_clear           = ec;
        model_cycle(rst, we, d, v, ec);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("top",       32'(data_stack_current_top),      32'(e[EW-1 -: WIDTH]));
            check_eq("next_top",  32'(data_stack_current_next_top), 32'(e[EW-WIDTH-1 -: WIDTH]));
            check_eq("dsp",       32'(dsp),                         32'(e[PW+1 -: PW]));
            check_eq("overflow",  32'(overflow),                    32'(e[1]));
            check_eq("underflow", 32'(underflow),                   32'(e[0]));
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        for (int i = 0; i < DEPTH; i++) m_cells[i] = '0;
        m_top = '0;
        m_sp  = 0;
        m_ov  = 1'b0;
        m_un  = 1'b0;
        reset = 1'b1; write_enable = 1'b0; delta = 2'b00;
        data_stack_next_value = '0; error_clear = 1'b0;

        // reset state
        step(1, 0, 2'b00, 16'h0, 0);
        step(1, 1, 2'b01, 16'h1234, 1);
        check_eq("rst_top", 32'(data_stack_current_top), 32'h0);
        check_eq("rst_dsp", 32'(dsp), 32'h0);

        // three pushes
        step(0, 1, 2'b01, 16'h0011, 0);
        step(0, 1, 2'b01, 16'h0022, 0);
        step(0, 1, 2'b01, 16'h0033, 0);
        check_eq("push3_top", 32'(data_stack_current_top), 32'h0033);
        check_eq("push3_n",   32'(data_stack_current_next_top), 32'h0022);
        check_eq("push3_dsp", 32'(dsp), 32'd3);

        // pop, then drop two
        step(0, 1, 2'b11, 16'h0055, 0);
        check_eq("pop_top", 32'(data_stack_current_top), 32'h0055);
        check_eq("pop_n",   32'(data_stack_current_next_top), 32'h0011);
        check_eq("pop_dsp", 32'(dsp), 32'd2);
        step(0, 1, 2'b10, 16'h0066, 0);
        check_eq("drop2_dsp", 32'(dsp), 32'd0);
        check_eq("drop2_n",   32'(data_stack_current_next_top), 32'h0);
        check_eq("drop2_un",  32'(underflow), 32'h0);

        // write_enable low holds everything
        for (int i = 0; i < 5; i++) step(0, 0, 2'b01, 16'hBEEF, 0);
        check_eq("hold_top", 32'(data_stack_current_top), 32'h0066);
        check_eq("hold_dsp", 32'(dsp), 32'd0);

        // overflow: DEPTH+1 pushes
        step(1, 0, 2'b00, 16'h0, 0);
        for (int i = 1; i <= DEPTH + 1; i++) step(0, 1, 2'b01, WIDTH'(i), 0);
        check_eq("ovf_dsp", 32'(dsp), 32'd16);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        check_eq("ovf_top", 32'(data_stack_current_top), 32'd17);
        check_eq("ovf_n",   32'(data_stack_current_next_top), 32'd15);
        step(0, 0, 2'b00, 16'h0, 1);
        check_eq("ovf_clear", 32'(overflow), 32'd0);

        // underflow cases
        step(1, 0, 2'b00, 16'h0, 0);
        step(0, 1, 2'b11, 16'h0007, 0);
        check_eq("unf_pop_flag", 32'(underflow), 32'd1);
        check_eq("unf_pop_dsp",  32'(dsp), 32'd0);
        step(0, 0, 2'b00, 16'h0, 1);
        step(0, 1, 2'b01, 16'h0008, 0);
        step(0, 1, 2'b10, 16'h0009, 0);
        check_eq("unf_drop_dsp",  32'(dsp), 32'd0);
        check_eq("unf_drop_flag", 32'(underflow), 32'd1);
        step(0, 1, 2'b11, 16'h000A, 1);
        check_eq("unf_set_wins", 32'(underflow), 32'd1);

        // reset overrides a push at dsp=5
        step(1, 0, 2'b00, 16'h0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 2'b01, WIDTH'(16'h0100 + i), 0);
        check_eq("pre_rst_dsp", 32'(dsp), 32'd5);
        step(1, 1, 2'b01, 16'hAAAA, 0);
        check_eq("mid_rst_top", 32'(data_stack_current_top), 32'h0);
        check_eq("mid_rst_dsp", 32'(dsp), 32'd0);
        step(0, 1, 2'b01, 16'h0042, 0);
        check_eq("post_rst_n",   32'(data_stack_current_next_top), 32'h0);
        check_eq("post_rst_dsp", 32'(dsp), 32'd1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), WIDTH'($urandom_range(0, 65535)),
                 ($urandom_range(0, 9) == 0));
        end

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
